// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite table controller.
package sprite_pkg;

  localparam logic [3:0] SPRITE_NONE   = 4'hF;
  localparam int         SPRITE_SIZE   = 32;
  localparam int         NUM_SLOTS_DEF = 16;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] id;
  } sprite_entry_t;

  typedef enum logic {
    ACCEPT = 1'b0,
    COMMIT = 1'b1
  } tbl_state_t;

  // Entry value for a hidden slot at its home position.
  function automatic sprite_entry_t empty_entry();
    sprite_entry_t e;
    e.x  = '0;
    e.y  = '0;
    e.id = SPRITE_NONE;
    return e;
  endfunction

endpackage

// File: rtl/sprite_table_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or
// after the pointer; the pointer moves past the winner on every grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] idx;
  logic          found;

  // Search from rr_ptr upward with wrap-around; a disabled arbiter grants nothing.
  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (enable && !found && valid[idx]) begin
        found       = 1'b1;
        gidx        = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  // Every grant is a transfer, so the pointer advances past the winner.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/sprite_table_ctrl.sv
// Sprite table controller: requesters write a shadow table; a frame_start
// copies it slot-by-slot into the active table seen by the pixel mapper.
module sprite_table_ctrl
  import sprite_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int NUM_SLOTS = NUM_SLOTS_DEF
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_start,
  input  logic                    clear_all,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [4*NUM_REQ-1:0]    req_slot,
  input  logic [10*NUM_REQ-1:0]   req_x,
  input  logic [10*NUM_REQ-1:0]   req_y,
  input  logic [4*NUM_REQ-1:0]    req_id,
  output logic [NUM_REQ-1:0]      req_grant,
  output logic [10*NUM_SLOTS-1:0] pos_x_flat,
  output logic [10*NUM_SLOTS-1:0] pos_y_flat,
  output logic [4*NUM_SLOTS-1:0]  sprite_id_flat,
  output logic                    busy,
  output logic                    commit_done,
  output logic                    slot_err
);

  tbl_state_t    state, state_nxt;
  logic [3:0]    cnt;
  logic          clear_pending;
  logic          clear_now;
  logic          arb_en;
  logic          last_copy;

  logic [NUM_REQ-1:0] grant;
  logic               wr_fire;
  logic               wr_oor;
  logic [3:0]         wr_slot;
  sprite_entry_t      wr_entry;

  sprite_entry_t shadow [NUM_SLOTS];
  sprite_entry_t active [NUM_SLOTS];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .Clk    (Clk),
    .Reset  (Reset),
    .valid  (req_valid),
    .enable (arb_en),
    .grant  (grant)
  );

  assign req_grant = grant;

  // Select the granted requester's fields and flag slots beyond the table.
  always_comb begin
    wr_slot  = '0;
    wr_entry = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant[r]) begin
        wr_slot     = req_slot[4*r +: 4];
        wr_entry.x  = req_x[10*r +: 10];
        wr_entry.y  = req_y[10*r +: 10];
        wr_entry.id = req_id[4*r +: 4];
      end
    end
    wr_fire = |grant;
    wr_oor  = ({1'b0, wr_slot} >= 5'(NUM_SLOTS));
  end

  // Next state and per-state controls; a pending clear suppresses grants.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    arb_en    = 1'b0;
    clear_now = 1'b0;
    last_copy = 1'b0;
    case (state)
      ACCEPT: begin
        clear_now = clear_all | clear_pending;
        arb_en    = ~clear_now;
        if (frame_start) state_nxt = COMMIT;
      end
      COMMIT: begin
        busy      = 1'b1;
        last_copy = (cnt == 4'(NUM_SLOTS - 1));
        if (last_copy) state_nxt = ACCEPT;
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  // State, copy counter, deferred clear and status pulses.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= ACCEPT;
      cnt           <= '0;
      clear_pending <= 1'b0;
      commit_done   <= 1'b0;
      slot_err      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= (state == COMMIT && !last_copy) ? cnt + 4'd1 : 4'd0;
      commit_done <= last_copy;
      slot_err    <= wr_fire & wr_oor;
      if (state == COMMIT && clear_all) begin
        clear_pending <= 1'b1;
      end else if (clear_now) begin
        clear_pending <= 1'b0;
      end
    end
  end

  // Shadow table: clear hides every slot, otherwise an in-range grant writes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) shadow[s] <= empty_entry();
    end else if (clear_now) begin
      for (int s = 0; s < NUM_SLOTS; s++) shadow[s].id <= SPRITE_NONE;
    end else if (wr_fire && !wr_oor) begin
      shadow[wr_slot] <= wr_entry;
    end
  end

  // Active table: one slot copied from shadow per COMMIT cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) active[s] <= empty_entry();
    end else if (state == COMMIT) begin
      active[cnt] <= shadow[cnt];
    end
  end

  // Flatten the active table onto the mapper-facing buses.
  always_comb begin
    pos_x_flat     = '0;
    pos_y_flat     = '0;
    sprite_id_flat = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      pos_x_flat[10*s +: 10]    = active[s].x;
      pos_y_flat[10*s +: 10]    = active[s].y;
      sprite_id_flat[4*s +: 4]  = active[s].id;
    end
  end

endmodule

// File: tb/tb_sprite_table_ctrl.sv
// Self-checking bench for sprite_table_ctrl: directed scenarios plus random
// traffic, all compared against a behavioural table model.
module tb_sprite_table_ctrl;

  localparam int NR = 2;
  localparam int NS = 16;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           frame_start, clear_all;
  logic [NR-1:0]  req_valid;
  logic [4*NR-1:0]  req_slot;
  logic [10*NR-1:0] req_x, req_y;
  logic [4*NR-1:0]  req_id;
  logic [NR-1:0]    req_grant;
  logic [10*NS-1:0] pos_x_flat, pos_y_flat;
  logic [4*NS-1:0]  sprite_id_flat;
  logic busy, commit_done, slot_err;

  always #5 Clk = ~Clk;

  sprite_table_ctrl #(.NUM_REQ(NR), .NUM_SLOTS(NS)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .clear_all(clear_all),
    .req_valid(req_valid), .req_slot(req_slot), .req_x(req_x), .req_y(req_y),
    .req_id(req_id), .req_grant(req_grant), .pos_x_flat(pos_x_flat),
    .pos_y_flat(pos_y_flat), .sprite_id_flat(sprite_id_flat), .busy(busy),
    .commit_done(commit_done), .slot_err(slot_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: shadow and active tables, commit progress, pending clear.
  logic [9:0] sx [NS], sy [NS], ax [NS], ay [NS];
  logic [3:0] sid [NS], aid [NS];
  bit m_busy, m_clr, m_done;
  int m_left, m_rr;

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      sx[s] = 0; sy[s] = 0; sid[s] = 4'hF;
      ax[s] = 0; ay[s] = 0; aid[s] = 4'hF;
    end
    m_busy = 0; m_clr = 0; m_done = 0; m_left = 0; m_rr = 0;
  endtask

  function automatic logic [10*NS-1:0] exp_x();
    logic [10*NS-1:0] v;
    for (int s = 0; s < NS; s++) v[10*s +: 10] = ax[s];
    return v;
  endfunction

  function automatic logic [10*NS-1:0] exp_y();
    logic [10*NS-1:0] v;
    for (int s = 0; s < NS; s++) v[10*s +: 10] = ay[s];
    return v;
  endfunction

  function automatic logic [4*NS-1:0] exp_id();
    logic [4*NS-1:0] v;
    for (int s = 0; s < NS; s++) v[4*s +: 4] = aid[s];
    return v;
  endfunction

  // One clock: drive at negedge, check against the model, advance the model.
  task automatic step(input bit fs, input bit clr, input logic [NR-1:0] v,
                      input logic [4*NR-1:0] sl, input logic [10*NR-1:0] xs,
                      input logic [10*NR-1:0] ys, input logic [4*NR-1:0] ids);
    logic [NR-1:0] eg;
    int gi, s, k;
    bit nd;
    @(negedge Clk);
    frame_start = fs; clear_all = clr; req_valid = v;
    req_slot = sl; req_x = xs; req_y = ys; req_id = ids;
    #1;
    eg = '0; gi = -1;
    if (!m_busy && !(clr || m_clr)) begin
      for (int i = 0; i < NR; i++)
        if (gi < 0 && v[(m_rr + i) % NR]) gi = (m_rr + i) % NR;
      if (gi >= 0) eg[gi] = 1'b1;
    end
    chk("grant", req_grant, eg);
    chk("busy", busy, m_busy);
    chk("commit_done", commit_done, m_done);
    chk("slot_err", slot_err, 1'b0);
    chk("pos_x", pos_x_flat, exp_x());
    chk("pos_y", pos_y_flat, exp_y());
    chk("sprite_id", sprite_id_flat, exp_id());
    if (commit_done) done_seen++;
    nd = 0;
    if (m_busy) begin
      k = NS - m_left;
      ax[k] = sx[k]; ay[k] = sy[k]; aid[k] = sid[k];
      if (clr) m_clr = 1;
      m_left--;
      if (m_left == 0) begin m_busy = 0; nd = 1; end
    end else begin
      if (clr || m_clr) begin
        for (int j = 0; j < NS; j++) sid[j] = 4'hF;
        m_clr = 0;
      end else if (gi >= 0) begin
        s = int'(sl[4*gi +: 4]);
        sx[s] = xs[10*gi +: 10]; sy[s] = ys[10*gi +: 10]; sid[s] = ids[4*gi +: 4];
        m_rr = (gi + 1) % NR;
      end
      if (fs) begin m_busy = 1; m_left = NS; end
    end
    m_done = nd;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, '0, '0, '0, '0, '0);
  endtask

  // Single-requester write, optionally with frame_start/clear in the same cycle.
  task automatic wr(input int r, input bit fs, input bit clr, input logic [3:0] slot,
                    input logic [9:0] x, input logic [9:0] y, input logic [3:0] id);
    logic [NR-1:0] v; logic [4*NR-1:0] sl, ids; logic [10*NR-1:0] xs, ys;
    v = '0; sl = '0; ids = '0; xs = '0; ys = '0;
    v[r] = 1'b1; sl[4*r +: 4] = slot; ids[4*r +: 4] = id;
    xs[10*r +: 10] = x; ys[10*r +: 10] = y;
    step(fs, clr, v, sl, xs, ys, ids);
  endtask

  logic [4*NS-1:0] idv;
  logic [4*NS-1:0] all_f;

  initial begin
    all_f = '1;
    Reset = 1'b1; frame_start = 0; clear_all = 0;
    req_valid = '0; req_slot = '0; req_x = '0; req_y = '0; req_id = '0;
    model_reset();

    // Reset state, then idle.
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_id", sprite_id_flat, all_f);
    chk("rst_x", pos_x_flat, '0);
    chk("rst_y", pos_y_flat, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", req_grant, '0);
    @(negedge Clk);
    Reset = 1'b0;
    idle(20);

    // Single write and commit.
    done_seen = 0;
    wr(0, 0, 0, 4'd3, 10'd100, 10'd200, 4'h2);
    step(1, 0, '0, '0, '0, '0, '0);
    idle(17);
    chk("t2_done_cnt", done_seen, 1);
    chk("t2_x3", pos_x_flat[39:30], 10'd100);
    chk("t2_y3", pos_y_flat[39:30], 10'd200);
    idv = all_f; idv[15:12] = 4'h2;
    chk("t2_ids", sprite_id_flat, idv);

    // Bring rr_ptr back to 0, then both requesters contend for slot 5.
    wr(1, 0, 0, 4'd7, 10'd1, 10'd2, 4'h1);
    step(0, 0, 2'b11, {4'd5, 4'd5}, {10'd33, 10'd11}, {10'd44, 10'd22}, {4'h4, 4'h3});
    chk("t3_g0", req_grant, 2'b01);
    step(0, 0, 2'b11, {4'd5, 4'd5}, {10'd33, 10'd11}, {10'd44, 10'd22}, {4'h4, 4'h3});
    chk("t3_g1", req_grant, 2'b10);
    step(0, 0, 2'b11, {4'd5, 4'd5}, {10'd33, 10'd11}, {10'd44, 10'd22}, {4'h4, 4'h3});
    chk("t3_g2", req_grant, 2'b01);
    step(0, 0, 2'b11, {4'd5, 4'd5}, {10'd33, 10'd11}, {10'd44, 10'd22}, {4'h4, 4'h3});
    chk("t3_g3", req_grant, 2'b10);
    step(1, 0, '0, '0, '0, '0, '0);
    idle(17);
    chk("t3_x5", pos_x_flat[59:50], 10'd33);
    chk("t3_id5", sprite_id_flat[23:20], 4'h4);

    // frame_start during COMMIT is ignored; a request waits for ACCEPT.
    done_seen = 0;
    step(1, 0, '0, '0, '0, '0, '0);
    idle(5);
    wr(0, 1, 0, 4'd9, 10'd5, 10'd6, 4'h7);
    repeat (10) wr(0, 0, 0, 4'd9, 10'd5, 10'd6, 4'h7);
    wr(0, 0, 0, 4'd9, 10'd5, 10'd6, 4'h7);
    chk("t4_first_accept_grant", req_grant, 2'b01);
    idle(20);
    chk("t4_done_cnt", done_seen, 1);

    // clear_all beats a simultaneous write; clear in COMMIT is deferred.
    wr(0, 0, 1, 4'd2, 10'd9, 10'd9, 4'h6);
    chk("t5_clr_grant", req_grant, '0);
    wr(1, 0, 0, 4'd4, 10'd77, 10'd88, 4'h5);
    step(1, 0, '0, '0, '0, '0, '0);
    idle(5);
    step(0, 1, '0, '0, '0, '0, '0);
    idle(10);
    wr(0, 0, 0, 4'd4, 10'd3, 10'd3, 4'h3);
    chk("t5_deferred_clr_grant", req_grant, '0);
    step(1, 0, '0, '0, '0, '0, '0);
    idle(17);
    chk("t5_ids_after_commit", sprite_id_flat, all_f);

    // Reset in the middle of a commit.
    wr(0, 0, 0, 4'd1, 10'd12, 10'd13, 4'h7);
    step(1, 0, '0, '0, '0, '0, '0);
    idle(17);
    step(1, 0, '0, '0, '0, '0, '0);
    idle(8);
    @(negedge Clk);
    Reset = 1'b1;
    frame_start = 0; clear_all = 0; req_valid = '0;
    #1;
    chk("t6_rst_ids", sprite_id_flat, all_f);
    chk("t6_rst_busy", busy, 1'b0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    done_seen = 0;
    idle(20);
    chk("t6_no_done", done_seen, 0);
    step(0, 0, 2'b11, {4'd6, 4'd6}, '0, '0, '0);
    chk("t6_rr_reset", req_grant, 2'b01);

    // Random traffic against the model.
    repeat (400) begin
      step(($urandom_range(0, 23) == 0), ($urandom_range(0, 39) == 0),
           NR'($urandom), (4*NR)'($urandom), (10*NR)'($urandom),
           (10*NR)'($urandom), (4*NR)'($urandom));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_table_ctrl.md
Name: sprite_table_ctrl

Overview:
Owns the 16-entry sprite table (X, Y, sprite ID per slot) that drives the per-pixel sprite mapper. Game-logic requesters write slot updates into a shadow table through a round-robin valid/grant arbiter. On each frame-start pulse the shadow table is copied into the active table, one slot per cycle, so the mapper sees stable positions for the whole visible frame. Sits between the game-logic FSMs and the mapper/VGA pixel path.

Parameters:
NUM_REQ, 2, number of write requesters
NUM_SLOTS, 16, number of sprite slots; slot index width is 4

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_start  in  1  one-cycle pulse at start of vertical blanking
clear_all  in  1  one-cycle pulse; hide all shadow slots
req_valid  in  NUM_REQ  per-requester write request
req_slot  in  4*NUM_REQ  target slot, requester r at [4r+3:4r]
req_x  in  10*NUM_REQ  new X position
req_y  in  10*NUM_REQ  new Y position
req_id  in  4*NUM_REQ  new sprite ID; 4'hF = slot empty
req_grant  out  NUM_REQ  combinational one-hot grant; transfer on valid&grant at edge
pos_x_flat  out  10*NUM_SLOTS  active X, slot s at [10s+9:10s]
pos_y_flat  out  10*NUM_SLOTS  active Y
sprite_id_flat  out  4*NUM_SLOTS  active ID
busy  out  1  high during COMMIT
commit_done  out  1  one-cycle pulse after the last slot copies
slot_err  out  1  one-cycle pulse when a granted slot index >= NUM_SLOTS

Behaviour:
- Reset (async, any state, including mid-commit): shadow and active IDs = 4'hF, all positions = 0, state = ACCEPT, rr_ptr = 0, commit counter = 0, clear_pending = 0. busy, commit_done and slot_err = 0.
- States: ACCEPT, COMMIT.
- ACCEPT arbitration:
  - Grant goes to the first valid requester searching from rr_ptr upward, with wrap-around.
  - At most one grant per cycle; grant is 0 when no request is valid.
  - On transfer: shadow[slot] <= {x, y, id}, and rr_ptr <= granted+1 mod NUM_REQ.
  - rr_ptr is unchanged when there is no transfer.
  - A requester holding valid gets exactly one write per granted cycle. Repeated grants across cycles are legal and each one writes.
- Out-of-range slot (slot >= NUM_SLOTS): grant still issues and rr_ptr still advances. The write is dropped and slot_err pulses the next cycle.
- clear_all in ACCEPT: all shadow IDs <= 4'hF in that cycle, and positions are untouched. req_grant is forced to 0 that cycle, so clear wins over a simultaneous write.
- clear_all in COMMIT: clear_pending is set. The clear is applied in the first ACCEPT cycle after COMMIT, with the same grant suppression.
- frame_start in ACCEPT:
  - A write transferred in the same cycle lands in shadow and is included in the commit.
  - The next state is COMMIT with the counter at 0.
- COMMIT:
  - req_grant is forced to 0 and busy = 1.
  - Each cycle: active[cnt] <= shadow[cnt] and cnt++.
  - After cnt = NUM_SLOTS-1 copies: state goes to ACCEPT and commit_done pulses on the first ACCEPT cycle.
  - Total commit latency: NUM_SLOTS cycles from the state entry.
- frame_start during COMMIT is ignored; there is no queuing.
- Active outputs are registered and change only during COMMIT or reset. The shadow table is never visible on the outputs.
- Widths: positions are carried unmodified at 10 bits. There is no arithmetic on the position fields.

Decomposition:
- Package sprite_pkg holds:
  - SPRITE_NONE = 4'hF
  - SPRITE_SIZE = 32
  - NUM_SLOTS_DEF = 16
  - typedef sprite_entry_t as a packed struct {x[9:0], y[9:0], id[3:0]}
  - enum tbl_state_t {ACCEPT, COMMIT}
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin, with inputs valid and enable, output one-hot grant, and rr_ptr state held internally with advance on transfer.

Test Plan:
1. Reset, then 20 idle cycles -> all sprite_id_flat = 4'hF, positions 0, busy 0, req_grant 0.
2. Req0 writes slot 3 = (100, 200, 4'h2), then frame_start -> busy for 16 cycles, then commit_done pulses; pos_x_flat slot 3 = 100, pos_y_flat slot 3 = 200, ID = 2, other IDs = F.
3. Both requesters hold valid for 4 cycles (rr_ptr = 0) -> grants alternate 01, 10, 01, 10. Both targeting slot 5: last writer (req1) wins in shadow.
4. frame_start while busy, 5 cycles into COMMIT -> ignored; exactly one commit_done. A req_valid asserted during COMMIT gets its grant on the first ACCEPT cycle.
5. clear_all in the same cycle as req0 valid -> no grant that cycle; all shadow IDs F. clear_all during COMMIT -> applied on the first ACCEPT cycle, then visible after the next commit.
6. Assert Reset at commit cycle 8 -> active IDs immediately all F. After release: state ACCEPT, no commit_done pulse.
